// File: rtl/nes_io_pkg.sv
// rtl/nes_io_pkg.sv - shared constants and types for the NES controller port
package nes_io_pkg;

  localparam logic [15:0] JOY1_ADDR = 16'h4016;
  localparam logic [15:0] JOY2_ADDR = 16'h4017;

  localparam int BTN_A      = 7;
  localparam int BTN_B      = 6;
  localparam int BTN_SELECT = 5;
  localparam int BTN_START  = 4;
  localparam int BTN_UP     = 3;
  localparam int BTN_DOWN   = 2;
  localparam int BTN_LEFT   = 1;
  localparam int BTN_RIGHT  = 0;

  localparam logic [3:0] RD_CNT_MAX = 4'd8;

  typedef logic [7:0] joypad_t;

endpackage

// File: rtl/joypad_shift_chan.sv
// rtl/joypad_shift_chan.sv - one controller's CD4021-style latch/shift chain
module joypad_shift_chan
  import nes_io_pkg::*;
#(
  parameter logic FILL_BIT = 1'b1
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    strobe,
  input  logic    sel,
  input  logic    rd,
  input  joypad_t buttons,
  output logic    serial_bit
);

  joypad_t    sr_q, sr_d;
  logic       rd_prev_q, rd_prev_d;
  logic [3:0] cnt_q, cnt_d;
  logic       rd_end;

  always_comb begin
    rd_prev_d = sel & rd;
    // The shift lands on the first cycle after the read leaves the port address
    rd_end    = rd_prev_q & ~sel;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    if (strobe) begin
      sr_d  = buttons;
      cnt_d = '0;
    end else if (rd_end) begin
      sr_d = {sr_q[6:0], FILL_BIT};
      if (cnt_q != RD_CNT_MAX) begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_q      <= '0;
      rd_prev_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sr_q      <= sr_d;
      rd_prev_q <= rd_prev_d;
      cnt_q     <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    assert (cnt_q <= RD_CNT_MAX);
  end

  assign serial_bit = sr_q[7];

endmodule

// File: rtl/nes_joypad_port.sv
// rtl/nes_joypad_port.sv - $4016/$4017 strobe register, decode and read mux
module nes_joypad_port
  import nes_io_pkg::*;
#(
  parameter logic       FILL_BIT = 1'b1,
  parameter logic [7:0] OPEN_BUS = 8'h40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addr,
  input  logic        WE,
  input  logic [7:0]  data_in,
  input  joypad_t     buttons_p1,
  input  joypad_t     buttons_p2,
  output logic [7:0]  data_out,
  output logic        hit,
  output logic        strobe
);

  logic sel1, sel2;
  logic sel1_prev_q, sel1_prev_d;
  logic strobe_q, strobe_d;
  logic bit_p1, bit_p2;
  logic unused_data;

  assign unused_data = ^data_in[7:1];

  always_comb begin
    sel1        = (addr == JOY1_ADDR);
    sel2        = (addr == JOY2_ADDR);
    sel1_prev_d = sel1;
    strobe_d    = strobe_q;
    // Only the first cycle of a $4016 write updates the latch; $4017 writes belong to the APU
    if (sel1 && WE && !sel1_prev_q) begin
      strobe_d = data_in[0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel1_prev_q <= 1'b0;
      strobe_q    <= 1'b0;
    end else begin
      sel1_prev_q <= sel1_prev_d;
      strobe_q    <= strobe_d;
    end
  end

  joypad_shift_chan #(.FILL_BIT(FILL_BIT)) u_chan_p1 (
    .clk        (clk),
    .reset      (reset),
    .strobe     (strobe_q),
    .sel        (sel1),
    .rd         (~WE),
    .buttons    (buttons_p1),
    .serial_bit (bit_p1)
  );

  joypad_shift_chan #(.FILL_BIT(FILL_BIT)) u_chan_p2 (
    .clk        (clk),
    .reset      (reset),
    .strobe     (strobe_q),
    .sel        (sel2),
    .rd         (~WE),
    .buttons    (buttons_p2),
    .serial_bit (bit_p2)
  );

  always_comb begin
    data_out = 8'h00;
    if (!WE && sel1) begin
      data_out = {OPEN_BUS[7:1], bit_p1};
    end else if (!WE && sel2) begin
      data_out = {OPEN_BUS[7:1], bit_p2};
    end
  end

  assign hit    = sel1 | sel2;
  assign strobe = strobe_q;

endmodule

// File: tb/tb_nes_joypad_port.sv
// tb/tb_nes_joypad_port.sv - randomized bench with a transaction-level controller model
module tb_nes_joypad_port;

  localparam logic       FILL = 1'b1;
  localparam logic [7:0] OPEN = 8'h40;

  logic        clk;
  logic        reset;
  logic [15:0] addr;
  logic        WE;
  logic [7:0]  data_in;
  logic [7:0]  buttons_p1, buttons_p2;
  logic [7:0]  data_out;
  logic        hit;
  logic        strobe;

  int errors = 0;
  int checks = 0;

  logic       m_strobe;
  logic [7:0] m_byte [2];
  int         m_cnt  [2];

  logic [7:0] exp_data;
  logic       exp_hit;
  logic       exp_strobe;
  logic       chk_en;

  nes_joypad_port dut (
    .clk        (clk),
    .reset      (reset),
    .addr       (addr),
    .WE         (WE),
    .data_in    (data_in),
    .buttons_p1 (buttons_p1),
    .buttons_p2 (buttons_p2),
    .data_out   (data_out),
    .hit        (hit),
    .strobe     (strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_data_out", data_out, exp_data);
      check("cyc_hit", {7'd0, hit}, {7'd0, exp_hit});
      check("cyc_strobe", {7'd0, strobe}, {7'd0, exp_strobe});
    end
  end

  function automatic logic [7:0] model_read(input int p);
    logic [7:0] btn;
    logic b;
    btn = (p == 0) ? buttons_p1 : buttons_p2;
    if (m_strobe) b = btn[7];
    else if (m_cnt[p] < 8) b = m_byte[p][7 - m_cnt[p]];
    else b = FILL;
    return {OPEN[7:1], b};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      addr     = 16'($urandom_range(0, 16'h3fff));
      WE       = 1'($urandom_range(0, 1));
      data_in  = 8'($urandom);
      exp_data = 8'h00;
      exp_hit  = 1'b0;
    end
  endtask

  task automatic set_buttons(input logic [7:0] p1, input logic [7:0] p2);
    step();
    addr       = 16'h0000;
    WE         = 1'b0;
    exp_data   = 8'h00;
    exp_hit    = 1'b0;
    buttons_p1 = p1;
    buttons_p2 = p2;
    idle(1);
  endtask

  task automatic do_read(input int p, input int len, output logic [7:0] first);
    step();
    addr     = (p == 0) ? 16'h4016 : 16'h4017;
    WE       = 1'b0;
    exp_hit  = 1'b1;
    exp_data = model_read(p);
    @(negedge clk);
    first = data_out;
    for (int i = 1; i < len; i++) step();
    if (!m_strobe && m_cnt[p] < 8) m_cnt[p]++;
  endtask

  task automatic do_write(input logic [15:0] a, input logic [7:0] d, input int len);
    step();
    addr     = a;
    WE       = 1'b1;
    data_in  = d;
    exp_hit  = (a == 16'h4016) || (a == 16'h4017);
    exp_data = 8'h00;
    step();
    if (a == 16'h4016) begin
      if (m_strobe && !d[0]) begin
        m_byte[0] = buttons_p1;
        m_byte[1] = buttons_p2;
      end
      if (m_strobe || d[0]) begin
        m_cnt[0] = 0;
        m_cnt[1] = 0;
      end
      m_strobe   = d[0];
      exp_strobe = d[0];
    end
    for (int i = 2; i < len; i++) step();
    data_in = 8'($urandom);
  endtask

  task automatic latch();
    do_write(16'h4016, 8'h01, 2);
    idle(1);
    do_write(16'h4016, 8'h00, 2);
    idle(1);
  endtask

  task automatic pulse_reset();
    step();
    reset      = 1'b0;
    addr       = 16'h0000;
    WE         = 1'b0;
    exp_data   = 8'h00;
    exp_hit    = 1'b0;
    exp_strobe = 1'b0;
    m_strobe   = 1'b0;
    m_byte[0]  = 8'h00;
    m_byte[1]  = 8'h00;
    m_cnt[0]   = 0;
    m_cnt[1]   = 0;
    @(negedge clk);
    check("reset_data_out", data_out, 8'h00);
    check("reset_strobe", {7'd0, strobe}, 8'h00);
    step();
    reset = 1'b1;
    idle(1);
  endtask

  logic [7:0] v;
  logic [7:0] t2_exp [10];

  initial begin
    reset      = 1'b0;
    addr       = 16'h0000;
    WE         = 1'b0;
    data_in    = 8'h00;
    buttons_p1 = 8'h00;
    buttons_p2 = 8'h00;
    exp_data   = 8'h00;
    exp_hit    = 1'b0;
    exp_strobe = 1'b0;
    m_strobe   = 1'b0;
    m_byte[0]  = 8'h00;
    m_byte[1]  = 8'h00;
    m_cnt[0]   = 0;
    m_cnt[1]   = 0;
    chk_en     = 1'b1;

    // 1: reset state, then an unlatched read gives open bus with a 0 bit
    @(negedge clk);
    check("t1_data_out", data_out, 8'h00);
    check("t1_strobe", {7'd0, strobe}, 8'h00);
    check("t1_hit", {7'd0, hit}, 8'h00);
    step();
    reset = 1'b1;
    idle(1);
    do_read(0, 3, v); check("t1_read", v, 8'h40);
    idle(1);

    // 2/3: A and Right pressed, ten reads including two fill reads
    t2_exp = '{8'h41, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h41, 8'h41, 8'h41};
    pulse_reset();
    set_buttons(8'b1000_0001, 8'h00);
    latch();
    for (int i = 0; i < 10; i++) begin
      do_read(0, 3, v);
      check($sformatf("t2_read%0d", i + 1), v, t2_exp[i]);
      idle(1);
    end

    // 4: strobe held high, reads never shift and track live buttons
    set_buttons(8'h80, 8'h00);
    do_write(16'h4016, 8'h01, 2);
    idle(1);
    for (int i = 0; i < 3; i++) begin
      do_read(0, 2, v); check("t4_held", v, 8'h41);
      idle(1);
    end
    set_buttons(8'h00, 8'h00);
    do_read(0, 2, v); check("t4_release", v, 8'h40);
    idle(1);
    do_write(16'h4016, 8'h00, 2);
    idle(1);

    // $4017 writes must not touch the strobe
    do_write(16'h4017, 8'h01, 3);
    idle(1);
    check("t4_4017_ignored", {7'd0, strobe}, 8'h00);

    // 5: ports are independent
    set_buttons(8'h80, 8'h40);
    latch();
    do_read(1, 3, v); check("t5_p2_r1", v, 8'h40);
    idle(1);
    do_read(1, 3, v); check("t5_p2_r2", v, 8'h41);
    idle(1);
    do_read(0, 3, v); check("t5_p1_r1", v, 8'h41);
    do_read(1, 3, v); check("t5_b2b_p2", v, 8'h40);
    idle(1);
    do_read(0, 2, v); check("t5_b2b_p1", v, 8'h40);
    idle(1);

    // 6: long read shifts once; reset mid-sequence clears, new latch reloads
    set_buttons(8'hA5, 8'h00);
    latch();
    do_read(0, 10, v); check("t6_long_r1", v, 8'h41);
    idle(1);
    do_read(0, 3, v); check("t6_r2", v, 8'h40);
    idle(1);
    do_read(0, 3, v); check("t6_r3", v, 8'h41);
    idle(1);
    pulse_reset();
    for (int i = 0; i < 3; i++) begin
      do_read(0, 3, v); check("t6_after_reset", v, 8'h40);
      idle(1);
    end
    set_buttons(8'hFF, 8'h00);
    latch();
    do_read(0, 3, v); check("t6_relatch", v, 8'h41);
    idle(1);

    // Randomized traffic checked cycle by cycle against the model
    for (int n = 0; n < 400; n++) begin
      int op;
      op = int'($urandom_range(0, 99));
      if (op < 50) begin
        do_read(int'($urandom_range(0, 1)), int'($urandom_range(1, 5)), v);
        idle(int'($urandom_range(1, 2)));
      end else if (op < 65) begin
        set_buttons(8'($urandom), 8'($urandom));
      end else if (op < 85) begin
        do_write(16'h4016, 8'($urandom), int'($urandom_range(2, 4)));
        idle(1);
      end else if (op < 95) begin
        do_write(16'h4017, 8'($urandom), int'($urandom_range(2, 3)));
        idle(1);
      end else if (op < 97) begin
        pulse_reset();
      end else begin
        idle(int'($urandom_range(1, 4)));
      end
    end

    idle(2);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
